// File: rtl/memory_access.sv
// rtl/memory_access.sv - data-memory access pipeline stage with req/ready handshake
//
// Sits downstream of execute. Non-memory instructions pass straight to the
// output register in one cycle. Loads and stores are issued on the
// mem_req/mem_ready handshake while upstream is stalled. The stage returns
// aligned, extended load data to write-back, or a hiccup for stores, for
// misaligned accesses and for timed-out accesses.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   result_input                    ALU result / effective address
//   rs2_value_input                 store data
//   read_status_input               load size  (00 none, 01 byte, 10 half, 11 word)
//   write_status_input              store size (same encoding)
//   load_signed_input               1 = sign-extend loads
//   destination_register_number_input, write_back_type_input, pc_input
//   stall                           upstream holds its inputs while 1
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_ready/mem_rdata  memory port
//   result_output, destination_register_number_output,
//   write_back_type_output, pc_output          write-back register
//   value_forward, register_forward, forward_enable  forwarding bus
//   misaligned, bus_error           one-cycle error pulses

`ifndef WB_HICCUP
`define WB_HICCUP 2'b00
`endif

module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_input,
  input  logic [31:0] rs2_value_input,
  input  logic [1:0]  read_status_input,
  input  logic [1:0]  write_status_input,
  input  logic        load_signed_input,
  input  logic [4:0]  destination_register_number_input,
  input  logic [1:0]  write_back_type_input,
  input  logic [31:0] pc_input,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result_output,
  output logic [4:0]  destination_register_number_output,
  output logic [1:0]  write_back_type_output,
  output logic [31:0] pc_output,
  output logic [31:0] value_forward,
  output logic [4:0]  register_forward,
  output logic        forward_enable,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // The abort fires on the ACCESS edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [31:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] timeout_count;

  // Attributes of the outstanding access, latched at issue.
  logic [1:0]  size_q;
  logic        sign_q;
  logic        store_q;
  logic [1:0]  offset_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [1:0]  type_q;

  // Decode of the instruction currently presented by execute.
  logic        store_in;
  logic [1:0]  size_in;
  logic        mem_op_in;
  logic        aligned_in;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;

  always_comb begin
    store_in   = (write_status_input != 2'b00);
    size_in    = store_in ? write_status_input : read_status_input;
    // A bubble never touches memory, whatever its status fields say.
    mem_op_in  = (write_back_type_input != `WB_HICCUP) && (size_in != 2'b00);
    aligned_in = 1'b1;
    wstrb_in   = 4'b0000;
    wdata_in   = rs2_value_input;
    case (size_in)
      2'b01: begin
        wstrb_in = 4'b0001 << result_input[1:0];
        wdata_in = {4{rs2_value_input[7:0]}};
      end
      2'b10: begin
        aligned_in = ~result_input[0];
        wstrb_in   = result_input[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{rs2_value_input[15:0]}};
      end
      2'b11: begin
        aligned_in = (result_input[1:0] == 2'b00);
        wstrb_in   = 4'b1111;
      end
      default: ;
    endcase
  end

  // Lane selection and extension of the returned load word.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  always_comb begin
    case (offset_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b01:   load_value = {{24{sign_q & load_byte[7]}}, load_byte};
      2'b10:   load_value = {{16{sign_q & load_half[15]}}, load_half};
      default: load_value = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                              <= IDLE;
      timeout_count                      <= 32'd0;
      size_q                             <= 2'b00;
      sign_q                             <= 1'b0;
      store_q                            <= 1'b0;
      offset_q                           <= 2'b00;
      rd_q                               <= 5'd0;
      pc_q                               <= 32'd0;
      type_q                             <= `WB_HICCUP;
      stall                              <= 1'b0;
      mem_req                            <= 1'b0;
      mem_we                             <= 1'b0;
      mem_addr                           <= 32'd0;
      mem_wdata                          <= 32'd0;
      mem_wstrb                          <= 4'b0000;
      result_output                      <= 32'd0;
      destination_register_number_output <= 5'd0;
      write_back_type_output             <= `WB_HICCUP;
      pc_output                          <= 32'd0;
      forward_enable                     <= 1'b0;
      misaligned                         <= 1'b0;
      bus_error                          <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op_in) begin
            result_output                      <= result_input;
            destination_register_number_output <= destination_register_number_input;
            write_back_type_output             <= write_back_type_input;
            pc_output                          <= pc_input;
            forward_enable <= (write_back_type_input != `WB_HICCUP) &&
                              (destination_register_number_input != 5'd0);
          end else if (!aligned_in) begin
            misaligned             <= 1'b1;
            write_back_type_output <= `WB_HICCUP;
            forward_enable         <= 1'b0;
          end else begin
            size_q                 <= size_in;
            sign_q                 <= load_signed_input;
            store_q                <= store_in;
            offset_q               <= result_input[1:0];
            rd_q                   <= destination_register_number_input;
            pc_q                   <= pc_input;
            type_q                 <= write_back_type_input;
            mem_req                <= 1'b1;
            stall                  <= 1'b1;
            mem_we                 <= store_in;
            mem_addr               <= {result_input[31:2], 2'b00};
            mem_wdata              <= store_in ? wdata_in : 32'd0;
            mem_wstrb              <= store_in ? wstrb_in : 4'b0000;
            write_back_type_output <= `WB_HICCUP;
            forward_enable         <= 1'b0;
            timeout_count          <= 32'd0;
            state                  <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            stall     <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            state     <= IDLE;
            if (!store_q) begin
              result_output                      <= load_value;
              destination_register_number_output <= rd_q;
              write_back_type_output             <= type_q;
              pc_output                          <= pc_q;
              forward_enable <= (type_q != `WB_HICCUP) && (rd_q != 5'd0);
            end else begin
              write_back_type_output <= `WB_HICCUP;
              forward_enable         <= 1'b0;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LAST)) begin
            mem_req                <= 1'b0;
            stall                  <= 1'b0;
            mem_we                 <= 1'b0;
            mem_wstrb              <= 4'b0000;
            bus_error              <= 1'b1;
            write_back_type_output <= `WB_HICCUP;
            forward_enable         <= 1'b0;
            state                  <= IDLE;
          end else begin
            timeout_count <= timeout_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Forwarding bus is a direct view of the write-back register.
  assign value_forward    = result_output;
  assign register_forward = destination_register_number_output;

endmodule
